// File: rtl/rv_mem_pkg.sv
// Shared instruction-memory definitions used by the loader and the fetch-side memory.
package rv_mem_pkg;
  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;
  localparam int IMEM_DEPTH = 256;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } ld_state_e;
endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler; word presents the completed word in the
// same cycle its last byte is accepted (word_ready).
module byte_packer
  import rv_mem_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            byte_en,
  input  logic [7:0]      byte_data,
  output logic [XLEN-1:0] word,
  output logic            word_ready
);
  logic [XLEN-1:0]   shift_q;
  logic [BCNT_W-1:0] byte_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shift_q  <= '0;
      byte_cnt <= '0;
    end else if (byte_en) begin
      shift_q[8*byte_cnt +: 8] <= byte_data;
      byte_cnt                 <= byte_cnt + BCNT_W'(1);
    end
  end

  // Merge the in-flight byte so the full word is available on the completing edge.
  always_comb begin
    word                  = shift_q;
    word[8*byte_cnt +: 8] = byte_data;
    word_ready            = byte_en && (byte_cnt == BCNT_W'(WORD_BYTES - 1));
  end
endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as 32-bit words and holds the core in
// reset until the whole image is written.
module imem_loader
  import rv_mem_pkg::*;
#(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LEN_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error
);
  ld_state_e        state, state_nxt;
  logic [LEN_W-1:0] len_q, word_cnt;
  logic             start_ok, too_big, load, accept, pk_ready;
  logic [XLEN-1:0]  pk_word;

  assign accept   = byte_valid && byte_ready;
  assign too_big  = 32'(num_words) > 32'(DEPTH);
  assign start_ok = start && (state == IDLE || state == DONE || state == ERROR);
  assign load     = start_ok && (state_nxt == RECV);

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (load),
    .byte_en    (accept),
    .byte_data  (byte_data),
    .word       (pk_word),
    .word_ready (pk_ready)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_reset = 1'b1;
    case (state)
      IDLE, DONE, ERROR: begin
        done       = (state == DONE);
        error      = (state == ERROR);
        core_reset = (state != DONE);
        if (start) begin
          if (num_words == '0) state_nxt = DONE;
          else if (too_big)    state_nxt = ERROR;
          else                 state_nxt = RECV;
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (pk_ready) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        busy      = 1'b1;
        state_nxt = (word_cnt + LEN_W'(1) == len_q) ? DONE : RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write address/data are captured on the completing edge and held until the next word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      word_cnt  <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      if (load) begin
        len_q    <= num_words;
        word_cnt <= '0;
      end
      if (state == RECV && pk_ready) begin
        mem_addr  <= BASE_ADDR + (XLEN'(word_cnt) << 2);
        mem_wdata <= pk_word;
      end
      if (state == WRITE) word_cnt <= word_cnt + LEN_W'(1);
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: dut_a (BASE 0x0) for protocol cases, dut_b (BASE 0x100) for the full-depth load.
module tb_imem_loader;
  logic        clock, reset, start_a, start_b, byte_valid;
  logic [15:0] num_words;
  logic [7:0]  byte_data;
  logic        byte_ready_a, mem_we_a, core_reset_a, busy_a, done_a, error_a;
  logic [31:0] mem_addr_a, mem_wdata_a;
  logic        byte_ready_b, mem_we_b, core_reset_b, busy_b, done_b, error_b;
  logic [31:0] mem_addr_b, mem_wdata_b;

  int n_chk = 0, n_pass = 0;
  logic [31:0] wa_addr[$], wa_data[$];
  int viol_a = 0, cnt_b = 0, seq_err_b = 0, viol_b = 0;
  logic [31:0] last_b = '0;
  logic [7:0]  bq[$];

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0), .LEN_W(16)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .core_reset(core_reset_a), .busy(busy_a), .done(done_a), .error(error_a));

  imem_loader #(.DEPTH(256), .BASE_ADDR(32'h100), .LEN_W(16)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .core_reset(core_reset_b), .busy(busy_b), .done(done_b), .error(error_b));

  always #5 clock = ~clock;

  function automatic logic [31:0] pat(input int w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'((w * 4 + k) ^ 'h5A);
    return r;
  endfunction

  always @(negedge clock) begin
    if (mem_we_a) begin
      wa_addr.push_back(mem_addr_a);
      wa_data.push_back(mem_wdata_a);
      if (byte_ready_a) viol_a++;
    end
    if (mem_we_b) begin
      if (mem_addr_b !== 32'h100 + 32'(cnt_b * 4) || mem_wdata_b !== pat(cnt_b)) seq_err_b++;
      if (done_b) viol_b++;
      last_b = mem_addr_b;
      cnt_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(input bit sel_b, input logic [15:0] nw);
    @(negedge clock);
    num_words = nw;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Present queued bytes; a byte is popped only on an edge where it was accepted.
  task automatic drive(input bit gaps, input int budget);
    int  cyc = 0;
    bit  acc;
    while (bq.size() > 0 && cyc < budget) begin
      @(negedge clock);
      byte_valid = gaps ? ~cyc[0] : 1'b1;
      byte_data  = bq[0];
      acc = byte_valid && (byte_ready_a || byte_ready_b);
      @(posedge clock);
      if (acc) void'(bq.pop_front());
      cyc++;
    end
    @(negedge clock);
    byte_valid = 1'b0;
    if (bq.size() != 0) begin
      chk("drive_timeout", bq.size(), 0);
      bq.delete();
    end
  endtask

  task automatic clear_log();
    wa_addr.delete();
    wa_data.delete();
    viol_a = 0;
  endtask

  task automatic check_two_words(input string tag);
    chk({tag, "_nwr"}, wa_addr.size(), 2);
    chk({tag, "_addr0"}, wa_addr[0], 32'h0);
    chk({tag, "_data0"}, wa_data[0], 32'h0000_0013);
    chk({tag, "_addr1"}, wa_addr[1], 32'h4);
    chk({tag, "_data1"}, wa_data[1], 32'h0010_0093);
    chk({tag, "_done"}, done_a, 1'b1);
    chk({tag, "_core_rst"}, core_reset_a, 1'b0);
    chk({tag, "_ready"}, byte_ready_a, 1'b0);
    chk({tag, "_busy"}, busy_a, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    clock = 0; reset = 1; start_a = 0; start_b = 0;
    byte_valid = 0; byte_data = '0; num_words = '0;
    wait_cyc(2);
    chk("rst_we", mem_we_a, 1'b0);
    chk("rst_addr_a", mem_addr_a, 32'h0);
    chk("rst_addr_b", mem_addr_b, 32'h100);
    chk("rst_wdata", mem_wdata_a, 32'h0);
    chk("rst_core_rst", core_reset_a, 1'b1);
    chk("rst_flags", {byte_ready_a, busy_a, done_a, error_a}, 4'b0000);
    reset = 0;
    wait_cyc(1);

    // zero-length load from IDLE
    pulse_start(0, 16'd0);
    chk("zero_done", done_a, 1'b1);
    chk("zero_core_rst", core_reset_a, 1'b0);
    wait_cyc(2);
    chk("zero_nwr", wa_addr.size(), 0);

    // two words back-to-back
    clear_log();
    pulse_start(0, 16'd2);
    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    drive(0, 100);
    wait_cyc(1);
    check_two_words("b2b");

    // same image with byte_valid gaps, restarted from DONE
    clear_log();
    pulse_start(0, 16'd2);
    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    drive(1, 200);
    wait_cyc(1);
    check_two_words("gap");
    chk("gap_ready_in_write", viol_a, 0);

    // oversize request, bytes offered must be ignored
    clear_log();
    pulse_start(0, 16'd257);
    chk("err_error", error_a, 1'b1);
    chk("err_done", done_a, 1'b0);
    chk("err_core_rst", core_reset_a, 1'b1);
    byte_valid = 1'b1; byte_data = 8'hFF;
    wait_cyc(4);
    chk("err_ready", byte_ready_a, 1'b0);
    byte_valid = 1'b0;
    chk("err_nwr", wa_addr.size(), 0);
    pulse_start(0, 16'd1);
    chk("recov_err_clr", error_a, 1'b0);
    chk("recov_busy", busy_a, 1'b1);
    bq = '{8'h13, 8'h00, 8'h00, 8'h00};
    drive(0, 50);
    wait_cyc(1);
    chk("recov_nwr", wa_addr.size(), 1);
    chk("recov_addr", wa_addr[0], 32'h0);
    chk("recov_data", wa_data[0], 32'h0000_0013);
    chk("recov_done", done_a, 1'b1);

    // full-depth load on the 0x100-based instance
    for (int wi = 0; wi < 256; wi++) begin
      w = pat(wi);
      for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
    end
    pulse_start(1, 16'd256);
    drive(0, 3000);
    wait_cyc(1);
    chk("depth_nwr", cnt_b, 256);
    chk("depth_last_addr", last_b, 32'h4FC);
    chk("depth_seq", seq_err_b, 0);
    chk("depth_done_early", viol_b, 0);
    chk("depth_done", done_b, 1'b1);
    chk("depth_core_rst", core_reset_b, 1'b0);

    // reset in the middle of a word, then a clean single-word load
    clear_log();
    pulse_start(0, 16'd1);
    bq = '{8'h11, 8'h22};
    drive(0, 50);
    reset = 1'b1;
    wait_cyc(1);
    chk("mid_core_rst", core_reset_a, 1'b1);
    chk("mid_flags", {byte_ready_a, busy_a, done_a}, 3'b000);
    reset = 1'b0;
    wait_cyc(1);
    pulse_start(0, 16'd1);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    drive(0, 50);
    wait_cyc(1);
    chk("mid_nwr", wa_addr.size(), 1);
    chk("mid_addr", wa_addr[0], 32'h0);
    chk("mid_data", wa_data[0], 32'hDDCC_BBAA);
    chk("mid_done", done_a, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch unit reads: accepts a byte stream, assembles little-endian 32-bit instruction words, writes them to consecutive word-aligned byte addresses.
- Holds the core (fetch unit, PC) in reset while a program is being loaded.
- Releases the core once the last word has been written, so fetch starts at BASE_ADDR with a complete image.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written (word-aligned).
- LEN_W, 16, width of the num_words length input.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load; sampled only in IDLE, DONE or ERROR.
- num_words  in  LEN_W  number of words to load; sampled on start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  32  byte address of the write.
- mem_wdata  out  32  assembled instruction word.
- core_reset  out  1  high holds the core (PC) in reset.
- busy  out  1  load in progress.
- done  out  1  last load completed.
- error  out  1  last start requested more than DEPTH words.

Behaviour:
- Reset (async): state=IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_reset=1, busy=0, done=0, error=0; internal byte_cnt=0, word_cnt=0.
- Byte transfer occurs only on a clock edge where byte_valid && byte_ready are both high.
- IDLE: core_reset=1. On start:
  - num_words==0 -> DONE.
  - num_words>DEPTH -> ERROR.
  - else latch num_words, word_cnt=0, byte_cnt=0, address=BASE_ADDR -> RECV.
- RECV: byte_ready=1, busy=1.
  - Each accepted byte goes into bits [8*byte_cnt+7 : 8*byte_cnt] of the shift word; first byte is bits [7:0].
  - byte_cnt increments modulo 4.
  - On the 4th accepted byte -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_wdata=assembled word, mem_addr=BASE_ADDR+4*word_cnt; byte_ready=0.
  - mem_we rises on the edge after the 4th byte is accepted (1-cycle latency).
  - word_cnt increments. If word_cnt+1==latched num_words -> DONE, else -> RECV.
- DONE: done=1, busy=0, core_reset=0, byte_ready=0. Bytes presented here are ignored, not consumed.
- ERROR: error=1, core_reset=1, busy=0, no writes.
- Restart: start in DONE or ERROR behaves as in IDLE, clearing done/error first. start during RECV/WRITE is ignored.
- byte_valid gaps: any number of idle cycles between bytes is legal; partial-word state is retained.
- Address arithmetic: 32-bit with wrap; the DEPTH check guarantees the last write is BASE_ADDR+4*(DEPTH-1).
- Reset mid-load: immediate return to IDLE; partial word is discarded; core_reset=1.
- mem_addr holds its last value outside WRITE; mem_we is 0 outside WRITE.

Decomposition:
- Shared package rv_mem_pkg: state encoding (IDLE, RECV, WRITE, DONE, ERROR), WORD_BYTES=4, XLEN=32, imem DEPTH constant shared with the fetch memory.
- One natural sub-module: byte_packer (4-byte little-endian assembler with byte_cnt and word_ready pulse). Loader FSM instantiates it.

Test Plan:
- start, num_words=2, bytes 13,00,00,00,93,00,10,00 back-to-back -> mem_we at addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; then done=1, core_reset=0, byte_ready=0.
- Same image with byte_valid toggling every other cycle -> identical writes; byte_ready=0 in each WRITE cycle; no byte lost or duplicated.
- start, num_words=0 -> DONE next cycle; no mem_we; core_reset=0.
- start, num_words=DEPTH+1 (257) -> error=1, core_reset=1, no mem_we ever; a subsequent start with num_words=1 clears error and loads normally.
- num_words=DEPTH, BASE_ADDR=0x100 -> 256 writes; last at 0x4FC; done asserted after the last write.
- reset after 2 bytes of the first word, then start num_words=1 with bytes AA,BB,CC,DD -> single write 0xDDCCBBAA at BASE_ADDR (no stale bytes).
